// File: rtl/memory_pkg.sv
// Shared definitions for the capture writer and the playback readers.
// Holds the writer state encoding and the default record geometry.
package memory_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } wr_state_t;

    localparam int DEF_DATA_SIZE   = 64;
    localparam int DEF_DATA_DEPTH  = 10501;
    localparam int DEF_ADDR_MODULE = 14;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port RAM: one write port, one registered read-first read port.
// Read latency 1 cycle; no reset on storage or read register so it maps to block RAM.
module capture_ram #(
    parameter int DATA_SIZE   = 64,
    parameter int DATA_DEPTH  = 10501,
    parameter int ADDR_MODULE = 14
) (
    input  logic                   clk_i,
    input  logic                   wr_en_i,
    input  logic [ADDR_MODULE-1:0] wr_addr_i,
    input  logic [DATA_SIZE-1:0]   wr_data_i,
    input  logic                   rd_en_i,
    input  logic [ADDR_MODULE-1:0] rd_addr_i,
    output logic [DATA_SIZE-1:0]   rd_data_o
);

    localparam int RAM_AW = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;

    logic [DATA_SIZE-1:0] mem_q [0:DATA_DEPTH-1];
    logic [DATA_SIZE-1:0] rd_data_q;

    // Callers keep addresses below DATA_DEPTH, so only the low bits index storage.
    if (ADDR_MODULE > RAM_AW) begin : g_hi_bits
        logic unused_hi;
        assign unused_hi = ^{wr_addr_i[ADDR_MODULE-1:RAM_AW], rd_addr_i[ADDR_MODULE-1:RAM_AW]};
    end

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i[RAM_AW-1:0]] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i[RAM_AW-1:0]];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/memory_writer.sv
// Captures a valid-qualified stream into RAM from address 0 until stop or full depth.
// Read port latency 1 cycle, usable in any state; out-of-range reads return zero.
module memory_writer
    import memory_pkg::*;
#(
    parameter int DATA_SIZE   = DEF_DATA_SIZE,
    parameter int DATA_DEPTH  = DEF_DATA_DEPTH,
    parameter int ADDR_MODULE = DEF_ADDR_MODULE
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_start,
    input  logic                   i_stop,
    input  logic                   i_valid,
    input  logic [DATA_SIZE-1:0]   i_data,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [ADDR_MODULE-1:0] o_count,
    output logic                   o_overflow,
    input  logic                   i_rd_en,
    input  logic [ADDR_MODULE-1:0] i_rd_addr,
    output logic [DATA_SIZE-1:0]   o_rd_data,
    output logic                   o_rd_valid
);

    localparam logic [ADDR_MODULE-1:0] LAST_ADDR  = ADDR_MODULE'(DATA_DEPTH - 1);
    localparam logic [ADDR_MODULE-1:0] DEPTH_ADDR = ADDR_MODULE'(DATA_DEPTH);

    wr_state_t              state_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   ovf_q;
    logic [ADDR_MODULE-1:0] count_q;
    logic [ADDR_MODULE-1:0] count_d;
    logic                   rd_vld_q;
    logic                   rd_oor_q;
    logic                   wr_en;
    logic                   rd_in_range;
    logic [DATA_SIZE-1:0]   ram_rd_data;

    // The write address is the running count: it never exceeds DATA_DEPTH-1 while capturing.
    assign wr_en       = (state_q == CAPTURE) && i_valid;
    assign count_d     = count_q + ADDR_MODULE'(1);
    assign rd_in_range = (i_rd_addr < DEPTH_ADDR);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            count_q <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (i_start) begin
                        state_q <= CAPTURE;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        ovf_q   <= 1'b0;
                        count_q <= '0;
                    end else if ((state_q == DONE) && i_valid) begin
                        ovf_q <= 1'b1;
                    end
                end
                CAPTURE: begin
                    if (i_valid) begin
                        count_q <= count_d;
                    end
                    if (i_stop || (i_valid && (count_q == LAST_ADDR))) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            rd_vld_q <= 1'b0;
            rd_oor_q <= 1'b0;
        end else begin
            rd_vld_q <= i_rd_en;
            rd_oor_q <= !rd_in_range;
        end
    end

    capture_ram #(
        .DATA_SIZE  (DATA_SIZE),
        .DATA_DEPTH (DATA_DEPTH),
        .ADDR_MODULE(ADDR_MODULE)
    ) u_ram (
        .clk_i    (i_clock),
        .wr_en_i  (wr_en),
        .wr_addr_i(count_q),
        .wr_data_i(i_data),
        .rd_en_i  (i_rd_en && rd_in_range),
        .rd_addr_i(i_rd_addr),
        .rd_data_o(ram_rd_data)
    );

    // RAM read register has no reset; gating keeps data zero after reset and on out-of-range reads.
    assign o_rd_data  = (rd_vld_q && !rd_oor_q) ? ram_rd_data : '0;
    assign o_rd_valid = rd_vld_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_overflow = ovf_q;
    assign o_count    = count_q;

endmodule
